// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for one bank of pre-skewed operand RAMs driving one edge of the systolic array.
// Optional FEED_STALL_EN adds a stall input that freezes FEED/DRAIN progress.
//
// state | meaning
// IDLE  | host owns the RAM port, waiting for start
// CLEAR | one-cycle accumulator clear
// FEED  | stream addresses 0..LENGTH-1, then one cycle for the last read to land
// DRAIN | array keeps shifting so the skewed wavefront reaches the far edge
// DONE  | one-cycle completion pulse
module systolic_feed_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 7,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FEED_STALL_EN
  input  logic                  stall,
`endif
  input  logic                  start,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_di,
  output logic                  host_rdy,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic                  pe_clear,
  output logic                  pe_en,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  FEED_LAST  = CNT_WIDTH'(LENGTH);
  localparam logic [CNT_WIDTH-1:0]  DRAIN_LAST = CNT_WIDTH'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(LENGTH - 1);
  localparam bit                    HAS_DRAIN  = (DRAIN_CYCLES > 0);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 stall_act;

  // Stall only matters while the run is actually streaming or draining.
`ifdef FEED_STALL_EN
  assign stall_act = stall & ((state == S_FEED) | (state == S_DRAIN));
`else
  assign stall_act = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (((state == S_FEED) || (state == S_DRAIN)) && !stall_act) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Aligned with the RAM's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= ram_en & ~ram_we & (state == S_FEED);
    end
  end

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_di    = '0;
    pe_clear  = 1'b0;
    pe_en     = 1'b0;
    case (state)
      S_IDLE: begin
        ram_en   = host_we;
        ram_we   = host_we;
        ram_addr = host_addr;
        ram_di   = host_di;
        if (start) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        pe_clear  = 1'b1;
        state_nxt = S_FEED;
      end
      S_FEED: begin
        if (cnt < FEED_LAST) begin
          ram_en   = ~stall_act;
          ram_addr = ADDR_WIDTH'(cnt);
        end else begin
          ram_addr = ADDR_LAST;
        end
        pe_en = data_valid & ~stall_act;
        if (!stall_act && (cnt == FEED_LAST)) begin
          state_nxt = HAS_DRAIN ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        pe_en = ~stall_act;
        if (!stall_act && (cnt == DRAIN_LAST)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign host_rdy = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl with a small 1-cycle-read RAM model on the feed port.
// Build with FEED_STALL_EN defined to include the stall scenario.
module tb_systolic_feed_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_di;
  logic          host_rdy;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic          pe_clear;
  logic          pe_en;
  logic          data_valid;
  logic          busy;
  logic          done;
`ifdef FEED_STALL_EN
  logic          stall;
`endif

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_mem [16];
  logic [DW-1:0] rdo;

  int total;
  int bad;

  systolic_feed_ctrl dut (
    .clk        (clk),
    .rst        (rst),
`ifdef FEED_STALL_EN
    .stall      (stall),
`endif
    .start      (start),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_di    (host_di),
    .host_rdy   (host_rdy),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_di     (ram_di),
    .pe_clear   (pe_clear),
    .pe_en      (pe_en),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        rdo <= mem[ram_addr];
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, pe_en, data_valid, pe_clear, host_rdy} !== 6'b000001) begin
      bad++;
      $display("FAIL reset_state: got busy,done,pe_en,dv,clr,rdy=%b want 000001",
               {busy, done, pe_en, data_valid, pe_clear, host_rdy});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({busy, done, pe_en, data_valid, pe_clear, host_rdy} !== 6'b000001) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 000001",
               {busy, done, pe_en, data_valid, pe_clear, host_rdy});
    end
  endtask

  task automatic test_host_load();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      host_we    = 1'b1;
      host_addr  = AW'(i);
      host_di    = (i == 3) ? 16'd42 : DW'(100 + i);
      exp_mem[i] = host_di;
      #1;
      total++;
      if ({ram_en, ram_we, ram_addr, ram_di} !== {1'b1, 1'b1, AW'(i), exp_mem[i]}) begin
        bad++;
        $display("FAIL host_write_%0d: got en=%b we=%b addr=%0d di=%0d want 1 1 %0d %0d",
                 i, ram_en, ram_we, ram_addr, ram_di, i, exp_mem[i]);
      end
    end
    @(posedge clk);
    #1;
    host_we = 1'b0;
  endtask

  // Called just after a clock edge; start is sampled at the next edge (E0), k counts cycles after E0.
  task automatic run_check(input string tag, input bit collide, input int s0, input int slen);
    int            stl_before;
    int            eff;
    bit            stl, feed, drain, e_rd, prev_rd, e_dv, e_pe, e_busy;
    logic [AW-1:0] e_addr, prev_addr;
    logic [7:0]    e_vec, a_vec;
    prev_rd   = 1'b0;
    prev_addr = '0;
    start     = 1'b1;
    if (collide) begin
      host_we   = 1'b1;
      host_addr = 4'd7;
      host_di   = 16'd77;
    end
    #1;
    if (collide) begin
      total++;
      if ({ram_en, ram_we, ram_addr, ram_di} !== {1'b1, 1'b1, 4'd7, 16'd77}) begin
        bad++;
        $display("FAIL %s start_with_write: got en=%b we=%b addr=%0d di=%0d want 1 1 7 77",
                 tag, ram_en, ram_we, ram_addr, ram_di);
      end
      exp_mem[7] = 16'd77;
    end
    for (int k = 0; k <= 27 + slen; k++) begin
      @(posedge clk);
      #1;
      start     = collide && (k == 5 || k == 20 || k == 25);
      host_we   = collide && (k >= 3) && (k <= 10);
      host_addr = 4'd9;
      host_di   = 16'hBEEF;
      stl       = (k >= s0) && (k < s0 + slen);
`ifdef FEED_STALL_EN
      stall = stl;
`endif
      #1;
      stl_before = (k < s0) ? 0 : ((k >= s0 + slen) ? slen : k - s0);
      eff    = k - stl_before;
      feed   = (eff >= 1) && (eff <= 17);
      drain  = (eff >= 18) && (eff <= 24);
      e_rd   = (eff >= 1) && (eff <= 16) && !stl;
      e_addr = ((eff >= 1) && (eff <= 16)) ? AW'(eff - 1) : 4'd15;
      e_dv   = prev_rd;
      e_pe   = !stl && ((feed && e_dv) || drain);
      e_busy = (eff <= 25);
      e_vec  = {e_rd, 1'b0, (eff == 0), e_pe, e_dv, e_busy, (eff == 25), !e_busy};
      a_vec  = {ram_en, ram_we, pe_clear, pe_en, data_valid, busy, done, host_rdy};
      total++;
      if (a_vec !== e_vec) begin
        bad++;
        $display("FAIL %s ctrl k=%0d: got en,we,clr,pe,dv,busy,done,rdy=%b want %b",
                 tag, k, a_vec, e_vec);
      end
      if (feed) begin
        total++;
        if ({ram_addr, ram_di} !== {e_addr, 16'd0}) begin
          bad++;
          $display("FAIL %s addr k=%0d: got addr=%0d di=%0d want addr=%0d di=0",
                   tag, k, ram_addr, ram_di, e_addr);
        end
      end
      if (e_dv) begin
        total++;
        if (rdo !== exp_mem[prev_addr]) begin
          bad++;
          $display("FAIL %s rdata k=%0d: got %0d want %0d", tag, k, rdo, exp_mem[prev_addr]);
        end
      end
      prev_rd   = e_rd;
      prev_addr = e_addr;
    end
  endtask

  task automatic test_full_run();
    run_check("full_run", 1'b0, -100, 0);
  endtask

  task automatic test_collisions();
    run_check("collide", 1'b1, -100, 0);
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    start = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #1;
    total++;
    if ({ram_en, ram_addr} !== {1'b1, 4'd8}) begin
      bad++;
      $display("FAIL midrun_addr8: got en=%b addr=%0d want 1 8", ram_en, ram_addr);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({ram_en, ram_we, pe_clear, pe_en, data_valid, busy, done, host_rdy} !== 8'b0000_0001) begin
      bad++;
      $display("FAIL midrun_abort: got %b want 00000001",
               {ram_en, ram_we, pe_clear, pe_en, data_valid, busy, done, host_rdy});
    end
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL midrun_no_done: got %0d active cycles want 0", done_seen);
    end
    run_check("restart", 1'b0, -100, 0);
  endtask

`ifdef FEED_STALL_EN
  task automatic test_stall();
    run_check("stall", 1'b0, 6, 3);
    stall = 1'b0;
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    host_we   = 1'b0;
    host_addr = '0;
    host_di   = '0;
`ifdef FEED_STALL_EN
    stall     = 1'b0;
`endif
    test_reset();
    test_host_load();
    test_full_run();
    test_collisions();
    test_reset_mid_run();
`ifdef FEED_STALL_EN
    test_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequencer for one bank of pre-skewed operand RAMs (16x16-bit, 1-cycle registered read) that feeds one edge of the 4x4 systolic array.
- Shares the RAM port between two users: host loads while idle, and a timed read burst during a matrix run.
- Drives the RAM control (en/we/addr/di) and the array control (clear, enable, data-valid). Reports busy and done.
- One instance per operand bank. All instances are started together.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- LENGTH, 16, number of RAM words streamed per run (addresses 0..LENGTH-1).
- DATA_WIDTH, 16, RAM data width.
- DRAIN_CYCLES, 7, cycles pe_en stays high after the last valid word (2N-1 for N=4).
- CNT_WIDTH, 5, width of the internal cycle counter. Must hold max(LENGTH, DRAIN_CYCLES).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset. Synchronous, active-high. One clock; reset is synchronous and active-high.
- start  in  1  run request. Sampled only in IDLE.
- host_we  in  1  host write strobe. Honoured only in IDLE.
- host_addr  in  ADDR_WIDTH  host write address.
- host_di  in  DATA_WIDTH  host write data.
- host_rdy  out  1  high when state==IDLE.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_di  out  DATA_WIDTH  RAM write data.
- pe_clear  out  1  one-cycle accumulator clear to the array.
- pe_en  out  1  array shift/MAC enable.
- data_valid  out  1  RAM read data on do is a valid operand this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the run completes.

Behaviour:
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- Reset: state=IDLE; counter=0; busy, done, pe_clear, pe_en and data_valid all 0. Reset mid-run aborts immediately with no done pulse.
- IDLE:
  - ram_en=ram_we=host_we, ram_addr=host_addr, ram_di=host_di. These are combinational pass-throughs.
  - start=1 moves to CLEAR. start and host_we in the same cycle: the write happens and the start is also accepted.
  - start outside IDLE is ignored.
  - host_we outside IDLE is dropped, and ram_we=0.
- CLEAR: lasts 1 cycle. pe_clear=1, ram_en=0.
- FEED: lasts LENGTH+1 cycles.
  - Cycles 0..LENGTH-1: ram_en=1, ram_we=0, ram_addr=counter (0,1,..,LENGTH-1).
  - Cycle LENGTH: ram_en=0, ram_addr held at LENGTH-1.
  - ram_di=0 throughout FEED.
- data_valid: a register, equal to the previous cycle's (ram_en & ~ram_we & state==FEED). It is therefore aligned with RAM do, and is high for exactly LENGTH consecutive cycles.
- pe_en=data_valid during FEED. pe_en=1 during DRAIN. pe_en=0 elsewhere.
- DRAIN: lasts DRAIN_CYCLES cycles, with data_valid=0. DRAIN_CYCLES=0 skips straight to DONE.
- DONE: lasts 1 cycle. done=1, busy=1, then return to IDLE.
- Counter: clears on every state entry. No wrap: transitions are taken on terminal count, so ram_addr never exceeds LENGTH-1.
- Total latency with defaults: start sampled at edge E0; done is high in the cycle after E25 (1 + 17 + 7 cycles). A new start is accepted in the cycle after done.

Optional Feature:
- Macro FEED_STALL_EN.
- Defined: adds input port stall (1 bit). In FEED and DRAIN, stall=1 does the following:
  - freezes the counter and the state;
  - forces ram_en=0 and pe_en=0;
  - makes data_valid low one cycle later.
  - Address sequence order and count are unchanged. Stall in CLEAR, DONE or IDLE has no effect.
- Undefined: no stall port; behaviour is identical to stall=0.

Test Plan:
- Reset then idle: rst high 2 cycles -> busy=done=pe_en=data_valid=pe_clear=0, host_rdy=1.
- Host load: in IDLE write addr 3 = 16'd42 -> ram_we=1, ram_addr=3, ram_di=42 the same cycle. A later run shows do=42 when data_valid is in its 4th cycle.
- Full run with defaults: start pulse at E0 ->
  - pe_clear high 1 cycle;
  - ram_addr 0..15 on 16 consecutive cycles;
  - data_valid high 16 cycles, starting 1 cycle after addr 0;
  - pe_en high 16+7 cycles;
  - done pulse in the cycle after E25.
- Collisions: start while busy has no effect on the timing. host_we=1 during FEED -> ram_we stays 0 and ram_addr follows the counter. start plus host_we together in IDLE -> write performed and run started.
- Reset mid-run: assert rst at FEED counter=8 -> next cycle IDLE, done never pulses, and a fresh start reproduces the full-run timing.
- FEED_STALL_EN: stall high 3 cycles at counter=5 -> addr 5 is held with ram_en=0, data_valid has a 3-cycle gap, and done is delayed by exactly 3 cycles.
